// File: rtl/branch_pdt_pkg.sv
// Shared constants for the IF-stage branch predictor: address width, default
// BTB index width and the 2-bit counter encodings.
package branch_pdt_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int PDT_IDX_W   = 4;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  function automatic logic cntPredictsTaken(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/branch_pdt_if.sv
// Training bus from ID: one resolved branch (PC, outcome, target) per cycle.
interface branch_pdt_if;
  import branch_pdt_pkg::*;

  logic                   upd_valid_i;
  logic [INST_ADDR_W-1:0] upd_pc_i;
  logic                   upd_taken_i;
  logic [INST_ADDR_W-1:0] upd_target_i;

  modport master (
    output upd_valid_i,
    output upd_pc_i,
    output upd_taken_i,
    output upd_target_i
  );

  modport slave (
    input upd_valid_i,
    input upd_pc_i,
    input upd_taken_i,
    input upd_target_i
  );

endinterface

// File: rtl/branch_pdt_sat_cnt2.sv
// Combinational next value of a 2-bit saturating confidence counter.
module sat_cnt2
  import branch_pdt_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_STRONG_T) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_STRONG_NT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pdt.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup of the fetch PC,
// training from ID, and a prediction record that travels into IF/ID.
module branch_pdt
  import branch_pdt_pkg::*;
#(
  parameter int IDX_W = PDT_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic [5:0]             stall,
  input  logic                   flush_i,
  branch_pdt_if.slave            upd,
  output logic                   branch_or_not,
  output logic [INST_ADDR_W-1:0] pdt_pc,
  output logic                   pred_taken_o,
  output logic [INST_ADDR_W-1:0] pred_pc_o
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  logic                   valid_q  [DEPTH];
  logic [TAG_W-1:0]       tag_q    [DEPTH];
  logic [INST_ADDR_W-1:0] target_q [DEPTH];
  logic [1:0]             cnt_q    [DEPTH];

  logic [IDX_W-1:0]       lookIdx;
  logic [TAG_W-1:0]       lookTag;
  logic                   lookHit;

  logic [IDX_W-1:0]       updIdx;
  logic [TAG_W-1:0]       updTag;
  logic                   updHit;
  logic [1:0]             cntNext;

  logic                   predTaken_q, predTaken_d;
  logic [INST_ADDR_W-1:0] predPc_q, predPc_d;

  logic                   unusedBits;

  assign lookIdx = pc[IDX_W+1:2];
  assign lookTag = pc[31:IDX_W+2];
  assign lookHit = valid_q[lookIdx] && (tag_q[lookIdx] == lookTag);

  assign branch_or_not = ce & lookHit & cntPredictsTaken(cnt_q[lookIdx]);
  assign pdt_pc        = branch_or_not ? target_q[lookIdx] : '0;

  assign updIdx = upd.upd_pc_i[IDX_W+1:2];
  assign updTag = upd.upd_pc_i[31:IDX_W+2];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  sat_cnt2 u_sat_cnt2 (
    .cnt      (cnt_q[updIdx]),
    .taken    (upd.upd_taken_i),
    .cnt_next (cntNext)
  );

  // Lookups read the array directly, so a same-cycle update to the same entry
  // is only seen from the following cycle on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_NT;
      end
    end else if (upd.upd_valid_i) begin
      if (updHit) begin
        cnt_q[updIdx] <= cntNext;
        if (upd.upd_taken_i) target_q[updIdx] <= upd.upd_target_i;
      end else if (upd.upd_taken_i) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= upd.upd_target_i;
        cnt_q[updIdx]    <= CNT_WEAK_T;
      end
    end
  end

  // Same flush/stall behaviour as the IF/ID instruction register it rides with.
  always_comb begin
    predTaken_d = predTaken_q;
    predPc_d    = predPc_q;
    if (flush_i) begin
      predTaken_d = 1'b0;
      predPc_d    = '0;
    end else if (stall[1] && !stall[2]) begin
      predTaken_d = 1'b0;
      predPc_d    = '0;
    end else if (!stall[1]) begin
      predTaken_d = branch_or_not;
      predPc_d    = pdt_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      predTaken_q <= 1'b0;
      predPc_q    <= '0;
    end else begin
      predTaken_q <= predTaken_d;
      predPc_q    <= predPc_d;
    end
  end

  assign pred_taken_o = predTaken_q;
  assign pred_pc_o    = predPc_q;

  assign unusedBits = ^{pc[1:0], upd.upd_pc_i[1:0], stall[5:3], stall[0]};

endmodule

// File: tb/tb_branch_pdt.sv
// Directed bench for branch_pdt: lookup, training, counter saturation,
// prediction register stall/flush handling and asynchronous reset.
module tb_branch_pdt;
  import branch_pdt_pkg::*;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush_i;
  logic        branch_or_not;
  logic [31:0] pdt_pc;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;

  int compared;
  int mismatched;

  branch_pdt_if updBus ();

  branch_pdt #(.IDX_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .pc            (pc),
    .stall         (stall),
    .flush_i       (flush_i),
    .upd           (updBus),
    .branch_or_not (branch_or_not),
    .pdt_pc        (pdt_pc),
    .pred_taken_o  (pred_taken_o),
    .pred_pc_o     (pred_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ceV, input logic [31:0] pcV,
                               input logic [5:0] stallV, input logic flushV,
                               input logic uValid, input logic [31:0] uPc,
                               input logic uTaken, input logic [31:0] uTgt);
    ce                  = ceV;
    pc                  = pcV;
    stall               = stallV;
    flush_i             = flushV;
    updBus.upd_valid_i  = uValid;
    updBus.upd_pc_i     = uPc;
    updBus.upd_taken_i  = uTaken;
    updBus.upd_target_i = uTgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("resetBon",       32'(branch_or_not), 32'h0);
    checkOutput("resetPdtPc",     pdt_pc,             32'h0);
    checkOutput("resetPredTaken", 32'(pred_taken_o),  32'h0);
    checkOutput("resetPredPc",    pred_pc_o,          32'h0);
    rst = 1'b1;
    tick();

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
    checkOutput("sameCycleNoBypass", 32'(branch_or_not), 32'h0);
    tick();

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("trainedBon",   32'(branch_or_not), 32'h1);
    checkOutput("trainedPdtPc", pdt_pc,             32'h100);
    tick();
    checkOutput("captureTaken", 32'(pred_taken_o), 32'h1);
    checkOutput("capturePc",    pred_pc_o,         32'h100);

    applyStimulus(1'b1, 32'h440, 6'b000110, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("aliasTagMiss", 32'(branch_or_not), 32'h0);
    tick();
    checkOutput("holdTaken", 32'(pred_taken_o), 32'h1);
    checkOutput("holdPc",    pred_pc_o,         32'h100);

    applyStimulus(1'b1, 32'h40, 6'b000010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("bubbleTaken", 32'(pred_taken_o), 32'h0);
    checkOutput("bubblePc",    pred_pc_o,         32'h0);

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("recaptureTaken", 32'(pred_taken_o), 32'h1);

    applyStimulus(1'b1, 32'h40, 6'b000110, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("flushTaken", 32'(pred_taken_o), 32'h0);
    checkOutput("flushPc",    pred_pc_o,         32'h0);

    // Counter walk on 0x40: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    checkOutput("cnt01Bon", 32'(branch_or_not), 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    checkOutput("cnt00Bon", 32'(branch_or_not), 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
    checkOutput("floorBon", 32'(branch_or_not), 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200);
    checkOutput("fromFloorBon", 32'(branch_or_not), 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200);
    checkOutput("cnt10Bon",   32'(branch_or_not), 32'h1);
    checkOutput("cnt10PdtPc", pdt_pc,             32'h200);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    checkOutput("satThenNtBon", 32'(branch_or_not), 32'h1);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("twoNtBon", 32'(branch_or_not), 32'h0);

    applyStimulus(1'b0, 32'h40, 6'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("ceLowBon",   32'(branch_or_not), 32'h0);
    checkOutput("ceLowPdtPc", pdt_pc,             32'h0);
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("ceLowTrainedBon", 32'(branch_or_not), 32'h1);

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h440, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("missNtNoChange", 32'(branch_or_not), 32'h1);

    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b1, 32'h440, 1'b1, 32'h300);
    tick();
    applyStimulus(1'b1, 32'h443, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("replaceBon",   32'(branch_or_not), 32'h1);
    checkOutput("replacePdtPc", pdt_pc,             32'h300);
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("evictedBon", 32'(branch_or_not), 32'h0);

    applyStimulus(1'b1, 32'h440, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("preResetPredTaken", 32'(pred_taken_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncResetBon",       32'(branch_or_not), 32'h0);
    checkOutput("asyncResetPredTaken", 32'(pred_taken_o),  32'h0);
    checkOutput("asyncResetPredPc",    pred_pc_o,          32'h0);
    rst = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h440, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("postResetMiss440", 32'(branch_or_not), 32'h0);
    applyStimulus(1'b1, 32'h40, 6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("postResetMiss40", 32'(branch_or_not), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
